instruction_loader: RTL and testbench

//  Boot-time program loader sitting directly upstream of the instruction memory write port.

---
 rtl/instruction_loader_pkg.sv | 24 ++
 rtl/instruction_loader_packer.sv | 47 ++++
 rtl/instruction_loader.sv | 158 +++++++++++++++
 tb/tb_instruction_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader_pkg
// Purpose  : Shared constants and FSM state encoding for the boot-time
//            instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_packer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader_packer
// Purpose  : Byte-to-word packer. Shifts stream bytes in LSB first and flags
//            the cycle in which the final byte of a word is being accepted.
// Ports    : clk, rstn        - clock, synchronous active-low reset
//            i_clear          - drop any partially assembled word
//            i_shift          - accept i_byte this cycle
//            i_byte           - stream byte
//            o_word           - assembled word including the current byte
//            o_word_valid     - i_shift carries the last byte of a word
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader_packer
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);

  // Only the three earlier bytes need storage; the fourth is taken straight
  // from the input so the word is ready in the same cycle it completes.
  logic [DATA_WIDTH-9:0] r_shift;
  logic [1:0]            r_cnt;

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= o_word[DATA_WIDTH-1:8];
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Purpose  : Boot-time program loader. Receives a length-prefixed byte
//            stream, assembles little-endian words and writes them to
//            consecutive instruction memory addresses. Fetch enable stays
//            low until the whole image has been written.
// Ports    : clk, rstn        - clock, synchronous active-low reset
//            start            - one-cycle pulse, begin a new load
//            in_valid/in_data - byte stream, in_ready accepts it
//            mem_a/mem_wd/mem_we - instruction memory write port
//            core_en          - fetch enable, high only with a valid image
//            busy/done/err    - load status (done/err sticky until start)
//            words_loaded     - words written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  core_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_loaded
);

  state_t                r_state;
  state_t                w_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_words_loaded;
  logic [LEN_WIDTH-1:0]  w_len_full;
  logic [DATA_WIDTH-1:0] r_mem_a;
  logic [DATA_WIDTH-1:0] r_mem_wd;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  r_core_en;
  logic                  w_restart;
  logic                  w_data_xfer;
  logic                  w_word_valid;

  // start is only honoured when no load is in flight.
  assign w_restart   = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                 r_state == ST_ERROR);
  assign w_data_xfer = in_valid && (r_state == ST_DATA);
  assign w_len_full  = {in_data, r_len[7:0]};

  instruction_loader_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .i_clear      (w_restart),
    .i_shift      (w_data_xfer),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    mem_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (w_len_full == '0)
            w_next = ST_DONE;
          else if (w_len_full > LEN_WIDTH'(MEM_CAPACITY))
            w_next = ST_ERROR;
          else
            w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (r_words_loaded + LEN_WIDTH'(1) == r_len)
          w_next = ST_DONE;
        else
          w_next = ST_DATA;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_next = ST_LEN_LO;
      end
      ST_ERROR: begin
        err = 1'b1;
        if (start) w_next = ST_LEN_LO;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_words_loaded <= '0;
      r_mem_a        <= '0;
      r_mem_wd       <= '0;
      r_core_en      <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Rises one cycle after DONE is entered, so it can never overlap the
      // final write; drops on the same edge that leaves DONE.
      r_core_en <= (r_state == ST_DONE) && (w_next == ST_DONE);
      if (w_restart) begin
        r_len          <= '0;
        r_words_loaded <= '0;
      end
      if (r_state == ST_LEN_LO && in_valid) r_len[7:0]  <= in_data;
      if (r_state == ST_LEN_HI && in_valid) r_len[15:8] <= in_data;
      // Address and data are captured with the last byte and then held
      // until the next word completes.
      if (w_word_valid) begin
        r_mem_a  <= DATA_WIDTH'(r_words_loaded);
        r_mem_wd <= w_word;
      end
      if (r_state == ST_WRITE) r_words_loaded <= r_words_loaded + LEN_WIDTH'(1);
    end
  end

  assign mem_a        = r_mem_a;
  assign mem_wd       = r_mem_wd;
  assign core_en      = r_core_en;
  assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_loader
// Purpose  : Self-checking bench for instruction_loader. Images are streamed
//            with random valid gaps and compared against writes predicted
//            directly from the stream format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int CAP = 10;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        core_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int          n_total = 0;
  int          n_bad = 0;
  int          core_we_viol = 0;
  logic [31:0] obs_a[$];
  logic [31:0] obs_wd[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_wd[$];

  always #5 clk = ~clk;

  instruction_loader #(
    .DATA_WIDTH   (32),
    .MEM_CAPACITY (CAP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .core_en      (core_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every memory write and flags fetch enable
  // overlapping a write.
  always @(negedge clk) begin
    if (rstn && mem_we) begin
      obs_a.push_back(mem_a);
      obs_wd.push_back(mem_wd);
    end
    if (core_en && mem_we) core_we_viol++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: length from the first two bytes, then each group of four
  // bytes is one word, byte k weighted by 256**k, at address = word number.
  task automatic build_exp(input bq_t b, output logic e_done, output logic e_err,
                           output logic [15:0] e_words);
    int n;
    n = int'(b[0]) + 256 * int'(b[1]);
    exp_a.delete();
    exp_wd.delete();
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_words = 16'd0;
    if (n > CAP) begin
      e_err = 1'b1;
    end else begin
      e_done  = 1'b1;
      e_words = 16'(n);
      for (int w = 0; w < n; w++) begin
        int base;
        base = 2 + 4 * w;
        exp_a.push_back(32'(w));
        exp_wd.push_back(32'(b[base]) + 32'(b[base+1]) * 256 +
                         32'(b[base+2]) * 65536 + 32'(b[base+3]) * 16777216);
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic pulse_start();
    logic prev_done;
    prev_done = done;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_words", 32'(words_loaded), 32'd0);
    if (prev_done) begin
      check("restart_core_en_drop", 32'(core_en), 32'd0);
      check("restart_done_clear", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Offers each byte until it is accepted; valid is asserted with
  // probability pct%. start is pulsed together with byte start_at.
  task automatic send_stream(input bq_t b, input int pct, input int start_at, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      bit taken;
      int guard;
      taken = 1'b0;
      guard = 0;
      while (!taken) begin
        in_valid = ($urandom_range(99) < pct);
        in_data  = in_valid ? b[i] : 8'($urandom);
        start    = (i == start_at) && (guard == 0);
        @(negedge clk);
        taken = in_valid && in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard++;
        if (!taken && guard > 200) begin
          check($sformatf("stream_byte%0d_accepted", i), 32'(taken), 32'd1);
          in_valid = 1'b0;
          ok = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input bq_t b, input int pct, input int start_at);
    logic        e_done;
    logic        e_err;
    logic [15:0] e_words;
    logic        done_t1;
    logic        core_t2;
    bit          ok;
    int          guard;
    build_exp(b, e_done, e_err, e_words);
    pulse_start();
    obs_a.delete();
    obs_wd.delete();
    core_we_viol = 0;
    send_stream(b, pct, start_at, ok);
    if (!ok) return;
    @(negedge clk);
    done_t1 = done;
    @(negedge clk);
    core_t2 = core_en;
    if (e_done && e_words == 16'd0) begin
      check({tag, "_done_after_len"}, 32'(done_t1), 32'd1);
      check({tag, "_core_en_2cyc"}, 32'(core_t2), 32'd1);
    end
    guard = 0;
    while (!(done || err) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_core_en"}, 32'(core_en), 32'(e_done));
    check({tag, "_words"}, 32'(words_loaded), 32'(e_words));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_nwrites"}, 32'(obs_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
      check($sformatf("%s_a%0d", tag, k), obs_a[k], exp_a[k]);
      check($sformatf("%s_wd%0d", tag, k), obs_wd[k], exp_wd[k]);
    end
    check({tag, "_core_en_with_we"}, 32'(core_we_viol), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic make_image(input int n, output bq_t b);
    b.delete();
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
    end
  endtask

  initial begin
    bq_t img;
    bq_t img2;
    bit  ok;

    // 1: reset and idle
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    obs_a.delete();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_no_writes", 32'(obs_a.size()), 32'd0);
    @(posedge clk);
    #1;

    // 2: reference image, continuous valid
    img2 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("t2", img2, 100, -1);
    check("t2_first_word", exp_wd[0], 32'h1234_5678);

    // 3: same image, 50% valid, start pulsed mid-stream (ignored)
    run_load("t3", img2, 50, 5);

    // 4: length one above capacity
    img = '{8'h0B, 8'h00};
    run_load("t4", img, 100, -1);

    // 5: zero length
    img = '{8'h00, 8'h00};
    run_load("t5", img, 100, -1);

    // length exactly at capacity, and a length with a nonzero high byte
    make_image(CAP, img);
    run_load("cap", img, 70, -1);
    img = '{8'h01, 8'h01};
    run_load("hi_len", img, 100, -1);

    // 6: reset after the fifth data byte, then a fresh full load
    pulse_start();
    img = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(img, 100, -1, ok);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_mem_a", mem_a, 32'd0);
    check("t6_mem_wd", mem_wd, 32'd0);
    check("t6_mem_we", 32'(mem_we), 32'd0);
    check("t6_core_en", 32'(core_en), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    run_load("t6_reload", img2, 100, -1);

    // random images, including out-of-range lengths
    for (int r = 0; r < 8; r++) begin
      int n;
      n = ($urandom_range(3) == 0) ? int'($urandom_range(300, CAP + 1)) : int'($urandom_range(CAP, 1));
      make_image(n, img);
      run_load($sformatf("rnd%0d", r), img, int'($urandom_range(100, 30)), int'($urandom_range(10, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
